uart_reg: RTL and testbench

UART_REG -- requirements
Module: uart_reg

---
 rtl/uart_reg_pkg.sv | 61 ++++++
 rtl/uart_reg_if.sv | 15 +
 rtl/uart_reg_shadow.sv | 37 +++
 rtl/uart_reg.sv | 179 +++++++++++++++++
 tb/tb_uart_reg.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_reg_pkg.sv
// Shared constants, encodings and helpers for the uart_reg register block.
package uart_reg_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 8;

   localparam logic [7:0] ADDR_ID        = 8'h00;
   localparam logic [7:0] ADDR_CTRL      = 8'h01;
   localparam logic [7:0] ADDR_FG        = 8'h02;
   localparam logic [7:0] ADDR_BG        = 8'h03;
   localparam logic [7:0] ADDR_CURSOR    = 8'h04;
   localparam logic [7:0] ADDR_FRAME_CNT = 8'h05;
   localparam logic [7:0] ADDR_STATUS    = 8'h06;
   localparam logic [7:0] ADDR_SCRATCH   = 8'h07;

   localparam logic [31:0] ID_VALUE    = 32'h5647_4131;
   localparam logic [1:0]  CTRL_RST    = 2'b01;
   localparam logic [11:0] FG_RST      = 12'hFFF;
   localparam logic [11:0] BG_RST      = 12'h000;
   localparam logic [9:0]  CUR_X_RST   = 10'h000;
   localparam logic [9:0]  CUR_Y_RST   = 10'h000;
   localparam logic [31:0] SCRATCH_RST = 32'h0000_0000;

   typedef enum logic [1:0] {
      UART_NONE  = 2'b00,
      UART_WRITE = 2'b01,
      UART_READ  = 2'b10,
      UART_RSVD  = 2'b11
   } uart_req_e;

   typedef enum logic [1:0] {
      RESP_IDLE  = 2'b00,
      RESP_WACK  = 2'b01,
      RESP_RDATA = 2'b10,
      RESP_ERR   = 2'b11
   } reg_resp_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_RESP = 2'b10
   } state_e;

   function automatic logic is_request(input logic [1:0] code);
      return (code == UART_WRITE) || (code == UART_READ);
   endfunction

   // STATUS accepts writes (W1C on bit0) even though most of it is read-only.
   function automatic logic is_writable(input logic [7:0] addr);
      case (addr)
         ADDR_CTRL, ADDR_FG, ADDR_BG, ADDR_CURSOR,
         ADDR_STATUS, ADDR_SCRATCH: return 1'b1;
         default:                   return 1'b0;
      endcase
   endfunction

   function automatic logic is_shadowed(input logic [7:0] addr);
      return (addr >= ADDR_CTRL) && (addr <= ADDR_CURSOR);
   endfunction

endpackage

// File: rtl/uart_reg_if.sv
// Request/response bus between the UART command side and the register block.
interface uart_reg_if;
   import uart_reg_pkg::*;

   logic [1:0]        UART_STATE;
   logic [DATA_W-1:0] UART_DATA;
   logic [ADDR_W-1:0] UART_ADDR;
   logic [1:0]        REG_STATE;
   logic [DATA_W-1:0] REG_DATA;

   modport master (output UART_STATE, UART_DATA, UART_ADDR,
                   input  REG_STATE, REG_DATA);
   modport slave  (input  UART_STATE, UART_DATA, UART_ADDR,
                   output REG_STATE, REG_DATA);
endinterface

// File: rtl/uart_reg_shadow.sv
// Frame-synchronous shadow bank: staging values are copied on each frame end.
module uart_reg_shadow
   import uart_reg_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_end,
   input  logic [1:0]  ctrl,
   input  logic [11:0] fg,
   input  logic [11:0] bg,
   input  logic [9:0]  cur_x,
   input  logic [9:0]  cur_y,
   output logic [1:0]  VGA_CTRL,
   output logic [11:0] VGA_FG_COLOR,
   output logic [11:0] VGA_BG_COLOR,
   output logic [9:0]  VGA_CURSOR_X,
   output logic [9:0]  VGA_CURSOR_Y
);

   // Shadow copy; a write landing on the same edge is picked up next frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         VGA_CTRL     <= CTRL_RST;
         VGA_FG_COLOR <= FG_RST;
         VGA_BG_COLOR <= BG_RST;
         VGA_CURSOR_X <= CUR_X_RST;
         VGA_CURSOR_Y <= CUR_Y_RST;
      end else if (frame_end) begin
         VGA_CTRL     <= ctrl;
         VGA_FG_COLOR <= fg;
         VGA_BG_COLOR <= bg;
         VGA_CURSOR_X <= cur_x;
         VGA_CURSOR_Y <= cur_y;
      end
   end

endmodule

// File: rtl/uart_reg.sv
// UART-driven register block: request FSM, address decode, staging and status
// registers; VGA-facing shadow copies live in uart_reg_shadow.
module uart_reg
   import uart_reg_pkg::*;
(
   input  logic        CLK_100M,
   input  logic        SYS_RST,
   uart_reg_if.slave   bus,
   input  logic        VGA_FRAME_END,
   output logic [1:0]  VGA_CTRL,
   output logic [11:0] VGA_FG_COLOR,
   output logic [11:0] VGA_BG_COLOR,
   output logic [9:0]  VGA_CURSOR_X,
   output logic [9:0]  VGA_CURSOR_Y
);

   state_e      state_r;
   logic [1:0]  req_code_r;
   logic [7:0]  req_addr_r;
   logic [31:0] req_data_r;
   reg_resp_e   reg_state_r;
   logic [31:0] reg_data_r;

   logic [1:0]  ctrl_r;
   logic [11:0] fg_r;
   logic [11:0] bg_r;
   logic [9:0]  cur_x_r;
   logic [9:0]  cur_y_r;
   logic [31:0] scratch_r;
   logic [31:0] frame_cnt_r;
   logic        drop_r;
   logic        pending_r;

   logic [31:0] rd_data_s;
   reg_resp_e   resp_s;
   logic [31:0] resp_data_s;
   logic        wr_en_s;

   assign bus.REG_STATE = reg_state_r;
   assign bus.REG_DATA  = reg_data_r;

   // Register read mux over the captured address; unused bits read as zero.
   always_comb begin
      rd_data_s = 32'h0000_0000;
      case (req_addr_r)
         ADDR_ID:        rd_data_s = ID_VALUE;
         ADDR_CTRL:      rd_data_s = {30'h0, ctrl_r};
         ADDR_FG:        rd_data_s = {20'h0, fg_r};
         ADDR_BG:        rd_data_s = {20'h0, bg_r};
         ADDR_CURSOR:    rd_data_s = {6'h0, cur_y_r, 6'h0, cur_x_r};
         ADDR_FRAME_CNT: rd_data_s = frame_cnt_r;
         ADDR_STATUS:    rd_data_s = {30'h0, pending_r, drop_r};
         ADDR_SCRATCH:   rd_data_s = scratch_r;
         default:        rd_data_s = 32'h0000_0000;
      endcase
   end

   // Execute-cycle decision: write enable plus the response to register.
   always_comb begin
      resp_s      = RESP_IDLE;
      resp_data_s = 32'h0000_0000;
      wr_en_s     = 1'b0;
      if (state_r == ST_EXEC) begin
         if (req_code_r == UART_WRITE) begin
            if (is_writable(req_addr_r)) begin
               wr_en_s = 1'b1;
               resp_s  = RESP_WACK;
            end else begin
               resp_s  = RESP_ERR;
            end
         end else begin
            if (req_addr_r <= ADDR_SCRATCH) begin
               resp_s      = RESP_RDATA;
               resp_data_s = rd_data_s;
            end else begin
               resp_s      = RESP_ERR;
            end
         end
      end else begin
         resp_s = RESP_IDLE;
      end
   end

   // Request FSM: capture in IDLE, execute, then present the response one cycle.
   always_ff @(posedge CLK_100M) begin
      if (SYS_RST) begin
         state_r     <= ST_IDLE;
         req_code_r  <= 2'b00;
         req_addr_r  <= 8'h00;
         req_data_r  <= 32'h0000_0000;
         reg_state_r <= RESP_IDLE;
         reg_data_r  <= 32'h0000_0000;
      end else begin
         reg_state_r <= RESP_IDLE;
         reg_data_r  <= 32'h0000_0000;
         case (state_r)
            ST_IDLE: begin
               if (is_request(bus.UART_STATE)) begin
                  req_code_r <= bus.UART_STATE;
                  req_addr_r <= bus.UART_ADDR;
                  req_data_r <= bus.UART_DATA;
                  state_r    <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               reg_state_r <= resp_s;
               reg_data_r  <= resp_data_s;
               state_r     <= ST_RESP;
            end
            ST_RESP: state_r <= ST_IDLE;
            default: state_r <= ST_IDLE;
         endcase
      end
   end

   // Staging registers, written only by an accepted write in the execute cycle.
   always_ff @(posedge CLK_100M) begin
      if (SYS_RST) begin
         ctrl_r    <= CTRL_RST;
         fg_r      <= FG_RST;
         bg_r      <= BG_RST;
         cur_x_r   <= CUR_X_RST;
         cur_y_r   <= CUR_Y_RST;
         scratch_r <= SCRATCH_RST;
      end else if (wr_en_s) begin
         case (req_addr_r)
            ADDR_CTRL:    ctrl_r    <= req_data_r[1:0];
            ADDR_FG:      fg_r      <= req_data_r[11:0];
            ADDR_BG:      bg_r      <= req_data_r[11:0];
            ADDR_CURSOR: begin
               cur_x_r <= req_data_r[9:0];
               cur_y_r <= req_data_r[25:16];
            end
            ADDR_SCRATCH: scratch_r <= req_data_r;
            default:      ;
         endcase
      end
   end

   // Frame counter and status bits; a new drop beats a same-cycle clear.
   always_ff @(posedge CLK_100M) begin
      if (SYS_RST) begin
         frame_cnt_r <= 32'h0000_0000;
         drop_r      <= 1'b0;
         pending_r   <= 1'b0;
      end else begin
         if (VGA_FRAME_END) begin
            frame_cnt_r <= frame_cnt_r + 32'd1;
         end
         if ((state_r != ST_IDLE) && is_request(bus.UART_STATE)) begin
            drop_r <= 1'b1;
         end else if (wr_en_s && (req_addr_r == ADDR_STATUS) && req_data_r[0]) begin
            drop_r <= 1'b0;
         end
         if (wr_en_s && is_shadowed(req_addr_r)) begin
            pending_r <= 1'b1;
         end else if (VGA_FRAME_END) begin
            pending_r <= 1'b0;
         end
      end
   end

   uart_reg_shadow u_shadow (
      .clk          (CLK_100M),
      .rst          (SYS_RST),
      .frame_end    (VGA_FRAME_END),
      .ctrl         (ctrl_r),
      .fg           (fg_r),
      .bg           (bg_r),
      .cur_x        (cur_x_r),
      .cur_y        (cur_y_r),
      .VGA_CTRL     (VGA_CTRL),
      .VGA_FG_COLOR (VGA_FG_COLOR),
      .VGA_BG_COLOR (VGA_BG_COLOR),
      .VGA_CURSOR_X (VGA_CURSOR_X),
      .VGA_CURSOR_Y (VGA_CURSOR_Y)
   );

endmodule

// File: tb/tb_uart_reg.sv
// Self-checking bench for uart_reg: directed scenarios plus random transactions
// checked against a register-map level reference model.
module tb_uart_reg;

   logic        clk = 1'b0;
   logic        rst;
   logic        fe;
   logic [1:0]  vga_ctrl;
   logic [11:0] vga_fg;
   logic [11:0] vga_bg;
   logic [9:0]  vga_x;
   logic [9:0]  vga_y;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   logic [31:0] m_stage  [0:7];
   logic [31:0] m_shadow [1:4];
   logic [31:0] m_fcnt;
   logic        m_drop;
   logic        m_pend;

   uart_reg_if bus();

   uart_reg dut (
      .CLK_100M      (clk),
      .SYS_RST       (rst),
      .bus           (bus),
      .VGA_FRAME_END (fe),
      .VGA_CTRL      (vga_ctrl),
      .VGA_FG_COLOR  (vga_fg),
      .VGA_BG_COLOR  (vga_bg),
      .VGA_CURSOR_X  (vga_x),
      .VGA_CURSOR_Y  (vga_y)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mask_of(input logic [7:0] addr);
      case (addr)
         8'h01:        return 32'h0000_0003;
         8'h02, 8'h03: return 32'h0000_0FFF;
         8'h04:        return 32'h03FF_03FF;
         8'h07:        return 32'hFFFF_FFFF;
         default:      return 32'h0000_0000;
      endcase
   endfunction

   function automatic logic [31:0] m_read(input logic [7:0] addr);
      case (addr)
         8'h00:   return 32'h5647_4131;
         8'h05:   return m_fcnt;
         8'h06:   return {30'h0, m_pend, m_drop};
         8'h01, 8'h02, 8'h03, 8'h04, 8'h07: return m_stage[addr[2:0]];
         default: return 32'h0000_0000;
      endcase
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 8; k++) m_stage[k] = 32'h0;
      m_stage[1] = 32'h1;
      m_stage[2] = 32'hFFF;
      for (int k = 1; k <= 4; k++) m_shadow[k] = m_stage[k];
      m_fcnt = 32'h0;
      m_drop = 1'b0;
      m_pend = 1'b0;
   endtask

   task automatic model_frame_end();
      for (int k = 1; k <= 4; k++) m_shadow[k] = m_stage[k];
      m_fcnt = m_fcnt + 32'd1;
      m_pend = 1'b0;
   endtask

   task automatic model_txn(input logic [1:0] code, input logic [7:0] addr,
                            input logic [31:0] data, input bit extra, input bit fev,
                            output logic [1:0] exp_rs, output logic [31:0] exp_rd);
      exp_rs = 2'b00;
      exp_rd = 32'h0;
      if (code == 2'b10) begin
         if (addr <= 8'h07) begin
            exp_rs = 2'b10;
            exp_rd = m_read(addr);
         end else begin
            exp_rs = 2'b11;
         end
      end else if (code == 2'b01) begin
         exp_rs = (mask_of(addr) != 32'h0 || addr == 8'h06) ? 2'b01 : 2'b11;
      end
      if (fev) model_frame_end();
      if (code == 2'b01 && exp_rs == 2'b01) begin
         if (addr == 8'h06) begin
            if (data[0]) m_drop = 1'b0;
         end else begin
            m_stage[addr[2:0]] = data & mask_of(addr);
            if (addr >= 8'h01 && addr <= 8'h04) m_pend = 1'b1;
         end
      end
      if (extra) m_drop = 1'b1;
   endtask

   task automatic idle_bus();
      bus.UART_STATE = 2'b00;
      bus.UART_ADDR  = 8'h00;
      bus.UART_DATA  = 32'h0;
   endtask

   task automatic do_req(input logic [1:0] code, input logic [7:0] addr, input logic [31:0] data,
                         input bit extra, input bit fev,
                         output logic [1:0] rs, output logic [31:0] rd, output logic [1:0] rs_after);
      bus.UART_STATE = code;
      bus.UART_ADDR  = addr;
      bus.UART_DATA  = data;
      cyc();
      if (extra) begin
         bus.UART_STATE = 2'b01;
         bus.UART_ADDR  = 8'h07;
         bus.UART_DATA  = $urandom;
      end else begin
         idle_bus();
      end
      fe = fev;
      cyc();
      idle_bus();
      fe = 1'b0;
      rs = bus.REG_STATE;
      rd = bus.REG_DATA;
      cyc();
      rs_after = bus.REG_STATE;
   endtask

   task automatic run(input string tag, input logic [1:0] code, input logic [7:0] addr,
                      input logic [31:0] data, input bit extra, input bit fev);
      logic [1:0]  exp_rs;
      logic [31:0] exp_rd;
      logic [1:0]  rs;
      logic [1:0]  rs_after;
      logic [31:0] rd;
      model_txn(code, addr, data, extra, fev, exp_rs, exp_rd);
      do_req(code, addr, data, extra, fev, rs, rd, rs_after);
      check({tag, " resp"}, {30'h0, rs}, {30'h0, exp_rs});
      check({tag, " data"}, rd, exp_rd);
      check({tag, " one-cycle"}, {30'h0, rs_after}, 32'h0);
   endtask

   task automatic check_shadow(input string tag);
      check({tag, " ctrl"}, {30'h0, vga_ctrl}, {30'h0, m_shadow[1][1:0]});
      check({tag, " fg"},   {20'h0, vga_fg},   {20'h0, m_shadow[2][11:0]});
      check({tag, " bg"},   {20'h0, vga_bg},   {20'h0, m_shadow[3][11:0]});
      check({tag, " x"},    {22'h0, vga_x},    {22'h0, m_shadow[4][9:0]});
      check({tag, " y"},    {22'h0, vga_y},    {22'h0, m_shadow[4][25:16]});
   endtask

   task automatic pulse_fe(input string tag);
      fe = 1'b1;
      cyc();
      fe = 1'b0;
      model_frame_end();
      check_shadow(tag);
   endtask

   initial begin
      logic [1:0]  code;
      logic [7:0]  addr;
      logic [31:0] data;
      bit          extra;
      bit          fev;

      rst = 1'b1;
      fe  = 1'b0;
      idle_bus();
      repeat (3) cyc();
      rst = 1'b0;
      model_reset();
      check("reset reg_state", {30'h0, bus.REG_STATE}, 32'h0);
      check("reset reg_data", bus.REG_DATA, 32'h0);
      check_shadow("reset shadow");

      run("read id", 2'b10, 8'h00, 32'h0, 1'b0, 1'b0);
      run("rsvd code", 2'b11, 8'h00, 32'h0, 1'b0, 1'b0);

      run("write fg", 2'b01, 8'h02, 32'h0000_0ABC, 1'b0, 1'b0);
      check_shadow("fg before frame");
      run("status pending", 2'b10, 8'h06, 32'h0, 1'b0, 1'b0);
      pulse_fe("fg after frame");
      run("status cleared", 2'b10, 8'h06, 32'h0, 1'b0, 1'b0);

      run("drop req", 2'b10, 8'h00, 32'h0, 1'b1, 1'b0);
      run("status drop", 2'b10, 8'h06, 32'h0, 1'b0, 1'b0);
      run("w1c status", 2'b01, 8'h06, 32'h0000_0001, 1'b0, 1'b0);
      run("status after w1c", 2'b10, 8'h06, 32'h0, 1'b0, 1'b0);
      run("scratch kept", 2'b10, 8'h07, 32'h0, 1'b0, 1'b0);

      run("w1c vs drop", 2'b01, 8'h06, 32'h0000_0001, 1'b1, 1'b0);
      run("drop wins", 2'b10, 8'h06, 32'h0, 1'b0, 1'b0);
      run("w1c again", 2'b01, 8'h06, 32'h0000_0001, 1'b0, 1'b0);

      run("write ro fcnt", 2'b01, 8'h05, 32'h0000_1234, 1'b0, 1'b0);
      run("read 0x20", 2'b10, 8'h20, 32'h0, 1'b0, 1'b0);
      run("fcnt unchanged", 2'b10, 8'h05, 32'h0, 1'b0, 1'b0);

      run("cursor at frame", 2'b01, 8'h04, 32'h0032_0064, 1'b0, 1'b1);
      check_shadow("cursor old");
      run("pending kept", 2'b10, 8'h06, 32'h0, 1'b0, 1'b0);
      pulse_fe("cursor new");
      check("cursor x 100", {22'h0, vga_x}, 32'd100);
      check("cursor y 50", {22'h0, vga_y}, 32'd50);

      for (int i = 0; i < 40; i++) begin
         code = 2'($urandom_range(1, 3));
         addr = 8'($urandom_range(0, 9));
         if (addr > 8'h07) addr = 8'($urandom_range(8, 255));
         data = $urandom;
         extra = (code != 2'b11) && ($urandom_range(0, 3) == 0);
         fev = ($urandom_range(0, 4) == 0);
         run($sformatf("rnd%0d", i), code, addr, data, extra, fev);
         if ($urandom_range(0, 2) == 0) pulse_fe($sformatf("rnd%0d frame", i));
      end
      run("rnd final fcnt", 2'b10, 8'h05, 32'h0, 1'b0, 1'b0);

      bus.UART_STATE = 2'b01;
      bus.UART_ADDR  = 8'h07;
      bus.UART_DATA  = 32'hFFFF_FFFF;
      cyc();
      idle_bus();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      model_reset();
      check("abort reg_state", {30'h0, bus.REG_STATE}, 32'h0);
      check("abort reg_data", bus.REG_DATA, 32'h0);
      check_shadow("abort shadow");
      cyc();
      check("abort late resp", {30'h0, bus.REG_STATE}, 32'h0);
      run("scratch after abort", 2'b10, 8'h07, 32'h0, 1'b0, 1'b0);
      run("ctrl after abort", 2'b10, 8'h01, 32'h0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
